// File: rtl/c1571_sd_responder.sv
`default_nettype none
// ============================================================================
//  Module   : c1571_sd_responder
//  Purpose  : Serves 512-byte block read/write requests from a disk-drive core
//             out of a byte-wide backing image memory. Requests outside the
//             image are acknowledged normally: reads return zeros, writes are
//             dropped, and err pulses at the end of the transfer.
//  Ports    : clk, reset       - clock, synchronous active-high reset
//             sd_lba/rd/wr     - block request (rd wins when both are high)
//             sd_ack           - high for the whole transfer (514 cycles)
//             sd_buff_*        - requester buffer side (addr, dout, din, wr)
//             img_blocks       - image size in 512-byte blocks
//             mem_*            - backing memory (addr, rd, dout, wr, din)
//             err              - 1-cycle pulse ending an out-of-range transfer
//  Revision : 1.0 - initial release
// ============================================================================
module c1571_sd_responder #(
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din,
  output logic              sd_buff_wr,
  input  logic [15:0]       img_blocks,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_dout,
  output logic              mem_wr,
  output logic [7:0]        mem_din,
  output logic              err
);

  localparam logic [9:0] c_LAST_K = 10'd512;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_XFER = 3'd1,
    WR_XFER = 3'd2,
    FINISH  = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t      r_state;
  logic [9:0]  r_k;
  logic [31:0] r_lba;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_k     <= 10'd0;
      r_lba   <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_k <= 10'd0;
          if (sd_rd) begin
            r_lba   <= sd_lba;
            r_state <= RD_XFER;
          end else if (sd_wr) begin
            r_lba   <= sd_lba;
            r_state <= WR_XFER;
          end
        end
        RD_XFER, WR_XFER: begin
          if (r_k == c_LAST_K) begin
            r_k     <= 10'd0;
            r_state <= FINISH;
          end else begin
            r_k <= r_k + 10'd1;
          end
        end
        FINISH:  r_state <= RELEASE;
        // A request still held from the finished transfer must drop first,
        // otherwise the same level would start a second transfer.
        RELEASE: if (!sd_rd && !sd_wr) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // All strobes decode from the state/counter registers, so each strobe is
  // aligned with the counter value that produced it and drops to zero
  // together with the registers on reset.
  logic              w_oor;
  logic              w_in_rd;
  logic              w_in_wr;
  logic              w_rd_fetch;
  logic              w_rd_strobe;
  logic              w_wr_strobe;
  logic [8:0]        w_k_lo;
  logic [8:0]        w_k_m1;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_offset;

  assign w_oor       = r_lba >= {16'd0, img_blocks};
  assign w_in_rd     = (r_state == RD_XFER);
  assign w_in_wr     = (r_state == WR_XFER);
  assign w_k_lo      = r_k[8:0];
  // At k=512 the low bits are 0, so k-1 wraps to 511 as required.
  assign w_k_m1      = w_k_lo - 9'd1;
  assign w_rd_fetch  = w_in_rd && (r_k < c_LAST_K);
  assign w_rd_strobe = w_in_rd && (r_k != 10'd0);
  assign w_wr_strobe = w_in_wr && (r_k != 10'd0);
  assign w_base      = {r_lba[ADDR_W-10:0], 9'd0};
  assign w_offset    = {{(ADDR_W-9){1'b0}}, (w_rd_fetch ? w_k_lo : w_k_m1)};

  // Reads fetch one cycle ahead of the buffer strobe (memory latency 1);
  // writes trail the buffer address by one cycle (requester latency 1).
  assign mem_addr     = (w_rd_fetch || w_wr_strobe) ? (w_base + w_offset) : '0;
  assign mem_rd       = w_rd_fetch && !w_oor;
  assign mem_wr       = w_wr_strobe && !w_oor;
  assign mem_din      = mem_wr ? sd_buff_din : 8'd0;
  assign sd_ack       = (r_state == RD_XFER) || (r_state == WR_XFER) ||
                        (r_state == FINISH);
  assign sd_buff_wr   = w_rd_strobe;
  assign sd_buff_addr = w_rd_strobe ? w_k_m1 :
                        (w_in_wr && (r_k < c_LAST_K)) ? w_k_lo : 9'd0;
  assign sd_buff_dout = (w_rd_strobe && !w_oor) ? mem_dout : 8'd0;
  assign err          = (r_state == FINISH) && w_oor;

endmodule
`default_nettype wire
